// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter (LSB first, idle-high line) behind a small byte FIFO.
// Latency: byte accepted in cycle N is popped in N+1, start bit on o_tx from N+2; frame = 10 (11 with parity) bit periods.
// Backpressure: o_wready = !full from registered pointers only; writes stall while the FIFO holds FIFO_DEPTH bytes.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx #(
  parameter int CLKS_PER_BIT = 250,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_wdata,
  input  logic                          i_wvalid,
  output logic                          o_wready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // FIFO storage; pointers carry one extra wrap bit to tell full from empty
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [7:0]  head_dat;

  // Transmit state
  state_t      state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        tx_q;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = i_wvalid && !fifo_full;
  assign head_dat   = mem_q[rd_ptr_q[AW-1:0]];

  assign o_wready = !fifo_full;
  assign o_level  = wr_ptr_q - rd_ptr_q;
  assign o_busy   = !fifo_empty || (state_q != S_IDLE);
  assign o_tx     = tx_q;

  // Pop the head when idle, or at the last stop-bit cycle so frames run back to back
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == S_IDLE) begin
        pop = 1'b1;
      end else if ((state_q == S_STOP) && (baud_q == BAUD_LAST)) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO pointer and storage update; simultaneous push and pop keep the level unchanged
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Framing FSM with registered line output; every state change restarts the baud count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q    <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shift_q <= head_dat;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^head_dat;
`endif
            tx_q    <= 1'b0;
            state_q <= S_START;
          end else begin
            tx_q    <= 1'b1;
          end
        end

        S_START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            baud_q    <= baud_q + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q  <= baud_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            if (pop) begin
              shift_q <= head_dat;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^head_dat;
`endif
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          baud_q    <= '0;
          bit_idx_q <= '0;
          tx_q      <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a 250-clock/bit instance observed by a frame monitor fed from a byte scoreboard,
// plus a 1-clock/bit instance checked cycle by cycle.
module tb_uart_tx;

  localparam int CPB = 250;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wdata = 8'h00;
  logic       wvalid = 1'b0;
  logic       wready;
  logic       tx;
  logic       busy;
  logic [2:0] level;

  logic [7:0] wdata1 = 8'h00;
  logic       wvalid1 = 1'b0;
  logic       wready1;
  logic       tx1;
  logic       busy1;
  logic [2:0] level1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] sb [$];
  int  last_start = 0;
  int  prev_start = 0;
  int  last_end = 0;
  int  last_gap = 0;
  int  frames = 0;
  bit  mon_busy = 1'b0;
  bit  mon_abort = 1'b0;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_wdata (wdata),
    .i_wvalid(wvalid),
    .o_wready(wready),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_level (level)
  );

  uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u_dut_fast (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_wdata (wdata1),
    .i_wvalid(wvalid1),
    .o_wready(wready1),
    .o_tx    (tx1),
    .o_busy  (busy1),
    .o_level (level1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level of frame bit i for byte b: start, d0..d7, optional even parity, stop
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[3'(i - 1)];
    if (NB == 11 && i == 9) return ^b;
    return 1'b1;
  endfunction

  // Drive one write on the slow instance; returns the accept cycle. Called at a negedge.
  task automatic put(input logic [7:0] d, output bit ok, output int acc);
    ok = 1'b0;
    acc = -1;
    wdata = d;
    wvalid = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      if (wready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      acc = cyc;
      sb.push_back(d);
      @(negedge clk);
    end
    wvalid = 1'b0;
  endtask

  // Wait for the slow instance and the monitor to drain everything queued
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (busy === 1'b0 && !mon_busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Decode every frame on the slow line and compare each bit period against the scoreboard head
  task automatic monitor();
    logic [7:0] b;
    logic       bad;
    logic       prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx === 1'b0 && rst === 1'b0) begin
        mon_busy = 1'b1;
        prev_start = last_start;
        last_start = cyc;
        last_gap = cyc - last_end - 1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: start bit at cycle %0d, required none (nothing queued)", cyc);
          b = 8'h00;
        end else begin
          b = sb.pop_front();
        end
        for (int i = 0; i < NB && !mon_abort; i++) begin
          bad = 1'b0;
          for (int c = 0; c < CPB; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (mon_abort) break;
            if (tx !== frame_bit(b, i)) bad = 1'b1;
          end
          if (!mon_abort) begin
            checks++;
            if (bad) begin
              errors++;
              $display("FAIL frame_bit: byte %h bit %0d line deviated from required %b during its %0d cycles",
                       b, i, frame_bit(b, i), CPB);
            end
          end
        end
        last_end = cyc;
        frames++;
        mon_abort = 1'b0;
        mon_busy = 1'b0;
      end
      prev = tx;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL reset_wready: got %b required 1", wready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", level); end
    checks++; if (tx1 !== 1'b1) begin errors++; $display("FAIL reset_tx_fast: got %b required 1", tx1); end
  endtask

  task automatic test_single();
    bit ok;
    int acc;
    int n;
    int f0;
    f0 = frames;
    put(8'h42, ok, acc);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept: write not accepted, required accept"); end
    n = 0;
    for (int i = 0; i < 30000; i++) begin
      if (busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    checks++; if (n != 1 + NB * CPB) begin errors++; $display("FAIL single_busy_len: got %0d cycles required %0d", n, 1 + NB * CPB); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: timeout, required drain"); end
    checks++; if (last_start - acc != 2) begin errors++; $display("FAIL single_latency: first low at accept+%0d required +2", last_start - acc); end
    checks++; if (frames != f0 + 1) begin errors++; $display("FAIL single_frames: got %0d required %0d", frames - f0, 1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acc;
    int f0;
    f0 = frames;
    put(8'h55, ok, acc);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level_a: got %0d required 1", level); end
    put(8'hAA, ok, acc);
    // 0x55 is popped in the same cycle 0xAA is pushed, so occupancy holds at 1
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level_b: got %0d required 1", level); end
    repeat (CPB * 5) @(negedge clk);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level_c: got %0d required 1", level); end
    repeat (CPB * NB) @(negedge clk);
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_level_d: got %0d required 0", level); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_idle: timeout, required drain"); end
    checks++; if (last_gap != 0) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles required 0", last_gap); end
    checks++; if (last_start - prev_start != NB * CPB) begin errors++; $display("FAIL b2b_period: got %0d required %0d", last_start - prev_start, NB * CPB); end
    checks++; if (frames != f0 + 2) begin errors++; $display("FAIL b2b_frames: got %0d required 2", frames - f0); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    bit all_ok;
    int acc [6];
    int f0;
    f0 = frames;
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(8'(i + 1), ok, acc[i]);
      if (!ok) all_ok = 1'b0;
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL full_accept5: a write timed out, required all 5 accepted"); end
    checks++; if (acc[4] - acc[0] != 4) begin errors++; $display("FAIL full_consecutive: span %0d required 4", acc[4] - acc[0]); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d required 4", level); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL full_wready: got %b required 0", wready); end
    put(8'h06, ok, acc[5]);
    checks++; if (!ok) begin errors++; $display("FAIL full_accept6: timeout, required accept"); end
    checks++; if (acc[5] - acc[0] != 2 + NB * CPB) begin errors++; $display("FAIL full_sixth_cycle: accept+%0d required +%0d", acc[5] - acc[0], 2 + NB * CPB); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level_after6: got %0d required 4", level); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_idle: timeout, required drain"); end
    checks++; if (frames != f0 + 6) begin errors++; $display("FAIL full_frames: got %0d required 6", frames - f0); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit bad;
    int acc;
    int f0;
    put(8'h0F, ok, acc);
    put(8'h10, ok, acc);
    put(8'h11, ok, acc);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL rst_queued: got %0d required 2", level); end
    // Land inside data bit 3 of 0x0F
    repeat (CPB * 4 + 100) @(negedge clk);
    mon_abort = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b required 1", tx); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_mid_level: got %0d required 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL rst_mid_wready: got %b required 1", wready); end
    for (int i = 0; i < 10 && mon_abort; i++) @(negedge clk);
    sb.delete();
    f0 = frames;
    bad = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      if (tx !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad) begin errors++; $display("FAIL rst_mid_quiet: line left high state after reset, required steady 1"); end
    put(8'h33, ok, acc);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_idle: timeout, required drain"); end
    checks++; if (frames != f0 + 1) begin errors++; $display("FAIL rst_mid_frames: got %0d required 1", frames - f0); end
  endtask

  task automatic test_one_clk_per_bit();
    logic [7:0] b;
    b = 8'hFF;
    wdata1 = b;
    wvalid1 = 1'b1;
    checks++; if (wready1 !== 1'b1) begin errors++; $display("FAIL fast_wready: got %b required 1", wready1); end
    @(negedge clk);
    wvalid1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (tx1 !== frame_bit(b, i)) begin
        errors++;
        $display("FAIL fast_bit: bit %0d got %b required %b", i, tx1, frame_bit(b, i));
      end
      @(negedge clk);
    end
    checks++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL fast_end: tx %b busy %b required tx 1 busy 0", tx1, busy1); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    int acc;
    put(8'h42, ok, acc);
    put(8'h43, ok, acc);
    // Middle of 0x42's parity bit: two ones, even parity 0
    repeat (9 * CPB + CPB / 2) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL parity_42: got %b required 0", tx); end
    // Middle of 0x43's parity bit: three ones, even parity 1
    repeat (11 * CPB) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL parity_43: got %b required 1", tx); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL parity_idle: timeout, required drain"); end
    checks++; if (last_start - prev_start != 11 * CPB) begin errors++; $display("FAIL parity_frame_len: got %0d required %0d", last_start - prev_start, 11 * CPB); end
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_one_clk_per_bit();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
